dca_step_inst_scheduler: RTL and testbench

- Queues blocked-step instructions written by the control side and replays each one a programmed number of times.
- Issues them one at a time to the DCA step controller over an issue handshake.
- Tracks steps issued but not yet completed, caps outstanding steps, and reports queue and step-group completion status to the memory-mapped control logic.

---
 rtl/dca_step_inst_scheduler_if.sv | 27 ++
 rtl/dca_step_inst_scheduler.sv | 102 ++++++++++
 tb/tb_dca_step_inst_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dca_step_inst_scheduler_if.sv
// Push and issue channels between the control side, the scheduler and the
// DCA step controller.
interface dca_step_inst_scheduler_if #(
    parameter int BW_STEP_INST = 32,
    parameter int BW_REPEAT    = 8
);
    logic                    push_valid;
    logic                    push_ready;
    logic [BW_STEP_INST-1:0] push_inst;
    logic [BW_REPEAT-1:0]    push_repeat;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [BW_STEP_INST-1:0] issue_inst;
    logic                    issue_last;
    logic                    step_done;

    // Control side plus step controller, as seen from outside the scheduler.
    modport master (
        output push_valid, push_inst, push_repeat, issue_ready, step_done,
        input  push_ready, issue_valid, issue_inst, issue_last
    );

    modport slave (
        input  push_valid, push_inst, push_repeat, issue_ready, step_done,
        output push_ready, issue_valid, issue_inst, issue_last
    );
endinterface

// File: rtl/dca_step_inst_scheduler.sv
// Blocked-step instruction queue: replays each entry repeat+1 times to the
// step controller while capping the number of in-flight steps.
module dca_step_inst_scheduler #(
    parameter int BW_STEP_INST    = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int BW_REPEAT       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rstnn,
    input  logic                            clear,
    dca_step_inst_scheduler_if.slave        bus,
    output logic [$clog2(FIFO_DEPTH):0]     num_queued,
    output logic [3:0]                      num_outstanding,
    output logic                            busy,
    output logic                            all_done,
    output logic                            err_underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BW_STEP_INST-1:0] mem_inst [FIFO_DEPTH];
    logic [BW_REPEAT-1:0]    mem_rep  [FIFO_DEPTH];

    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, count_nxt;
    logic [BW_REPEAT-1:0] rep_cnt;
    logic [3:0]         outstanding, out_nxt;
    logic               push_en, accept, pop, err_set, busy_nxt;

    assign bus.push_ready  = (count != (AW+1)'(FIFO_DEPTH));
    assign bus.issue_valid = (count != '0) & (outstanding < 4'(MAX_OUTSTANDING)) & ~clear;
    assign bus.issue_inst  = mem_inst[rd_ptr];
    assign bus.issue_last  = bus.issue_valid & (rep_cnt == mem_rep[rd_ptr]);

    assign push_en = bus.push_valid & bus.push_ready;
    assign accept  = bus.issue_valid & bus.issue_ready;
    assign pop     = accept & bus.issue_last;

    always_comb begin
        count_nxt = count;
        if (push_en & ~pop)      count_nxt = count + 1'b1;
        else if (pop & ~push_en) count_nxt = count - 1'b1;
    end

    // A step_done coinciding with an accept cancels it, even at zero.
    always_comb begin
        out_nxt = outstanding;
        err_set = 1'b0;
        if (accept & ~bus.step_done) begin
            out_nxt = outstanding + 4'd1;
        end else if (bus.step_done & ~accept) begin
            if (outstanding == 4'd0) err_set = 1'b1;
            else                     out_nxt = outstanding - 4'd1;
        end
    end

    assign busy_nxt = (count_nxt != '0) | (out_nxt != 4'd0);

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_en & ~clear) begin
            mem_inst[wr_ptr] <= bus.push_inst;
            mem_rep[wr_ptr]  <= bus.push_repeat;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rep_cnt       <= '0;
            outstanding   <= 4'd0;
            err_underflow <= 1'b0;
            all_done      <= 1'b0;
        end else if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rep_cnt       <= '0;
            outstanding   <= 4'd0;
            err_underflow <= 1'b0;
            all_done      <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rep_cnt <= '0;
            end else if (accept) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
            count       <= count_nxt;
            outstanding <= out_nxt;
            if (err_set) err_underflow <= 1'b1;
            all_done    <= busy & ~busy_nxt;
        end
    end

    assign num_queued      = count;
    assign num_outstanding = outstanding;
    assign busy            = (count != '0) | (outstanding != 4'd0);
endmodule

// File: tb/tb_dca_step_inst_scheduler.sv
// Directed and random stimulus for dca_step_inst_scheduler, compared every
// cycle against a queue-based behavioural model.
module tb_dca_step_inst_scheduler;
    localparam int BW_I  = 32;
    localparam int DEPTH = 8;
    localparam int BW_R  = 8;
    localparam int MAXO  = 4;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    logic clear = 1'b0;
    logic [$clog2(DEPTH):0] num_queued;
    logic [3:0] num_outstanding;
    logic busy, all_done, err_underflow;

    always #5 clk = ~clk;

    dca_step_inst_scheduler_if #(.BW_STEP_INST(BW_I), .BW_REPEAT(BW_R)) bus();

    dca_step_inst_scheduler #(
        .BW_STEP_INST(BW_I), .FIFO_DEPTH(DEPTH), .BW_REPEAT(BW_R), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .bus(bus),
        .num_queued(num_queued), .num_outstanding(num_outstanding),
        .busy(busy), .all_done(all_done), .err_underflow(err_underflow)
    );

    typedef struct { logic [BW_I-1:0] inst; int rep; } ent_t;
    ent_t mq[$];
    int   m_rep_cnt, m_out;
    bit   m_err, m_all_done;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_done_pulses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rep_cnt  = 0;
        m_out      = 0;
        m_err      = 1'b0;
        m_all_done = 1'b0;
    endtask

    task automatic cycle(input bit pv, input logic [BW_I-1:0] inst, input int rep,
                         input bit ir, input bit sd, input bit clr);
        bit e_iv, e_last, e_pr, acc, pushed, old_busy, new_busy;
        bus.push_valid  = pv;
        bus.push_inst   = inst;
        bus.push_repeat = BW_R'(rep);
        bus.issue_ready = ir;
        bus.step_done   = sd;
        clear           = clr;
        #1;
        e_pr   = (mq.size() != DEPTH);
        e_iv   = (mq.size() != 0) && (m_out < MAXO) && !clr;
        e_last = e_iv && (m_rep_cnt == mq[0].rep);
        chk("push_ready", 64'(bus.push_ready), 64'(e_pr));
        chk("issue_valid", 64'(bus.issue_valid), 64'(e_iv));
        chk("issue_last", 64'(bus.issue_last), 64'(e_last));
        if (e_iv) chk("issue_inst", 64'(bus.issue_inst), 64'(mq[0].inst));
        chk("num_queued", 64'(num_queued), 64'(mq.size()));
        chk("num_outstanding", 64'(num_outstanding), 64'(m_out));
        chk("busy", 64'(busy), 64'((mq.size() != 0) || (m_out != 0)));
        chk("all_done", 64'(all_done), 64'(m_all_done));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        if (bus.issue_valid && ir) n_acc++;
        if (all_done) n_done_pulses++;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            old_busy = (mq.size() != 0) || (m_out != 0);
            acc    = e_iv && ir;
            pushed = pv && e_pr;
            if (acc) begin
                if (e_last) begin
                    void'(mq.pop_front());
                    m_rep_cnt = 0;
                end else begin
                    m_rep_cnt++;
                end
            end
            if (pushed) mq.push_back('{inst, rep});
            if (acc && !sd) m_out++;
            else if (sd && !acc) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
            new_busy   = (mq.size() != 0) || (m_out != 0);
            m_all_done = old_busy && !new_busy;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ir, input bit sd);
        cycle(1'b0, '0, 0, ir, sd, 1'b0);
    endtask

    initial begin
        int a0;
        bus.push_valid = 1'b0; bus.push_inst = '0; bus.push_repeat = '0;
        bus.issue_ready = 1'b0; bus.step_done = 1'b0;
        model_reset();
        #12;
        chk("reset_push_ready", 64'(bus.push_ready), 64'd1);
        chk("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        rstnn = 1'b1;
        @(negedge clk);

        // Single entry replayed three times.
        cycle(1'b1, 32'h0000_1234, 2, 1'b1, 1'b0, 1'b0);
        a0 = n_acc;
        repeat (3) idle(1'b1, 1'b0);
        chk("t1_accepts", 64'(n_acc - a0), 64'd3);
        repeat (3) idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);

        // Fill to full, drop the ninth, drain in order; second fill wraps.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 9; i++) cycle(1'b1, 32'hA000_0000 + 32'(f*16 + i), 0, 1'b0, 1'b0, 1'b0);
            repeat (10) idle(1'b1, 1'b1);
        end

        // Outstanding cap.
        cycle(1'b1, 32'hBEEF_0001, 9, 1'b1, 1'b0, 1'b0);
        a0 = n_acc;
        repeat (6) idle(1'b1, 1'b0);
        chk("t3_cap_accepts", 64'(n_acc - a0), 64'(MAXO));
        idle(1'b0, 1'b1);
        a0 = n_acc;
        idle(1'b1, 1'b0);
        chk("t3_one_more", 64'(n_acc - a0), 64'd1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        chk("t3_same_cycle", 64'(num_outstanding), 64'(MAXO - 1));
        cycle(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);

        // Two-entry sequence and single all_done pulse.
        cycle(1'b1, 32'hC0DE_0001, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC0DE_0002, 0, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b1, 1'b0);
        a0 = n_done_pulses;
        repeat (2) idle(1'b0, 1'b1);
        repeat (3) idle(1'b0, 1'b0);
        chk("t4_all_done_once", 64'(n_done_pulses - a0), 64'd1);

        // Underflow is sticky until clear.
        idle(1'b0, 1'b1);
        repeat (2) idle(1'b0, 1'b0);
        cycle(1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0);

        // Clear with queued and in-flight work: no all_done.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD000_0000 + 32'(i), 0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle(1'b1, 1'b0);
        a0 = n_done_pulses;
        cycle(1'b0, '0, 0, 1'b1, 1'b0, 1'b1);
        repeat (2) idle(1'b0, 1'b0);
        chk("t6_no_all_done", 64'(n_done_pulses - a0), 64'd0);

        // Asynchronous reset mid-issue.
        cycle(1'b1, 32'hE000_0001, 3, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b1, 1'b0);
        #2 rstnn = 1'b0;
        #1;
        chk("arst_push_ready", 64'(bus.push_ready), 64'd1);
        chk("arst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("arst_num_queued", 64'(num_queued), 64'd0);
        chk("arst_outstanding", 64'(num_outstanding), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bit pv, ir, sd, clr;
            pv  = ($urandom_range(0, 99) < 50);
            ir  = ($urandom_range(0, 99) < 70);
            sd  = (m_out > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 199) == 0);
            cycle(pv, $urandom, $urandom_range(0, 3), ir, sd, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
